// File: rtl/uart_axi_pkg.sv
// Shared constants for the UART AXI4-Lite responder: response codes,
// register offsets and status-register bit positions.
package uart_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [3:0] OFS_RX   = 4'h0;
    localparam logic [3:0] OFS_TX   = 4'h4;
    localparam logic [3:0] OFS_STAT = 4'h8;

    localparam int STAT_RX_VALID = 0;
    localparam int STAT_RX_FULL  = 1;
    localparam int STAT_TX_EMPTY = 2;
    localparam int STAT_TX_FULL  = 3;

endpackage

// File: rtl/uart_axi_responder_byte_fifo.sv
// byte_fifo: circular byte buffer with wrapping pointers and an occupancy count.
// Pop is qualified by the registered count, so push+pop while full is legal.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_axi_responder.sv
// AXI4-Lite responder exposing RX (pop) and TX (push) byte FIFOs of a UART.
// Define UART_AXI_STATUS_EN to make offset 0x8 a readable status register.
module uart_axi_responder
    import uart_axi_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    input  logic [31:0] s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic [7:0]  rx_in_data,
    input  logic        rx_in_valid,
    output logic        rx_in_ready,
    output logic [7:0]  tx_out_data,
    output logic        tx_out_valid,
    input  logic        tx_out_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    // Handshakes: a transfer occurs on the rising edge where valid && ready are both
    // high; valid and its payload are held stable until that edge.
    logic          ar_hs, aw_hs, w_hs;
    logic [AW-1:0] ar_ofs;
    logic [31:0]   rd_data;
    logic [1:0]    rd_resp;
    logic          rx_pop, rx_full, rx_empty;
    logic [7:0]    rx_head;
    logic [CW-1:0] rx_count;
    logic          tx_push, tx_full, tx_empty;
    logic [CW-1:0] tx_count;

    logic          aw_held, w_held;
    logic [AW-1:0] aw_ofs_q;
    logic [7:0]    wbyte_q;
    logic          wstrb0_q;
    logic [AW-1:0] cur_ofs;
    logic [7:0]    cur_byte;
    logic          cur_strb0;
    logic          wr_fire;
    logic [1:0]    wr_resp;

    assign s_arready    = ~s_rvalid;
    assign s_awready    = ~aw_held;
    assign s_wready     = ~w_held;
    assign ar_hs        = s_arvalid && s_arready;
    assign aw_hs        = s_awvalid && s_awready;
    assign w_hs         = s_wvalid && s_wready;
    assign ar_ofs       = s_araddr[AW-1:0];
    assign rx_in_ready  = ~rx_full;
    assign tx_out_valid = ~tx_empty;
    assign rx_pop       = ar_hs && (ar_ofs == AW'(OFS_RX)) && !rx_empty;

    byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (rx_in_valid && rx_in_ready),
        .push_data (rx_in_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (tx_push),
        .push_data (cur_byte),
        .pop       (tx_out_valid && tx_out_ready),
        .head      (tx_out_data),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_SLVERR;
        if (ar_ofs == AW'(OFS_RX) && !rx_empty) begin
            rd_data = {24'h0, rx_head};
            rd_resp = RESP_OKAY;
        end
`ifdef UART_AXI_STATUS_EN
        else if (ar_ofs == AW'(OFS_STAT)) begin
            rd_data[STAT_RX_VALID] = ~rx_empty;
            rd_data[STAT_RX_FULL]  = rx_full;
            rd_data[STAT_TX_EMPTY] = tx_empty;
            rd_data[STAT_TX_FULL]  = tx_full;
            rd_resp = RESP_OKAY;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
            s_rresp  <= '0;
        end else if (ar_hs) begin
            s_rvalid <= 1'b1;
            s_rdata  <= rd_data;
            s_rresp  <= rd_resp;
        end else if (s_rvalid && s_rready) begin
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
            s_rresp  <= '0;
        end
    end

    // A beat arriving this cycle is used directly so AW/W in the same cycle
    // still produce bvalid on the following cycle.
    assign cur_ofs   = aw_held ? aw_ofs_q : s_awaddr[AW-1:0];
    assign cur_byte  = w_held ? wbyte_q : s_wdata[7:0];
    assign cur_strb0 = w_held ? wstrb0_q : s_wstrb[0];
    assign wr_fire   = (aw_held || aw_hs) && (w_held || w_hs) && !s_bvalid;

    always_comb begin
        wr_resp = RESP_SLVERR;
        tx_push = 1'b0;
        if (wr_fire && cur_ofs == AW'(OFS_TX)) begin
            if (!cur_strb0) begin
                wr_resp = RESP_OKAY;
            end else if (!tx_full) begin
                wr_resp = RESP_OKAY;
                tx_push = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_ofs_q <= '0;
            wbyte_q  <= '0;
            wstrb0_q <= 1'b0;
            s_bvalid <= 1'b0;
            s_bresp  <= '0;
        end else begin
            if (aw_hs) begin
                aw_held  <= 1'b1;
                aw_ofs_q <= s_awaddr[AW-1:0];
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                wbyte_q  <= s_wdata[7:0];
                wstrb0_q <= s_wstrb[0];
            end
            if (wr_fire) begin
                s_bvalid <= 1'b1;
                s_bresp  <= wr_resp;
            end else if (s_bvalid && s_bready) begin
                s_bvalid <= 1'b0;
                s_bresp  <= '0;
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{s_araddr[31:AW], s_awaddr[31:AW], s_wdata[31:8],
                           s_wstrb[3:1], rx_count, tx_count};

endmodule

// File: tb/tb_uart_axi_responder.sv
// Randomised scoreboard bench for uart_axi_responder: queue-based reference
// model of both FIFOs and the register map, with a decoupled response monitor.
module tb_uart_axi_responder;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        clk, rstn;
    logic [31:0] s_araddr;
    logic        s_arvalid, s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid, s_rready;
    logic [31:0] s_awaddr;
    logic        s_awvalid, s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid, s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid, s_bready;
    logic [7:0]  rx_in_data;
    logic        rx_in_valid, rx_in_ready;
    logic [7:0]  tx_out_data;
    logic        tx_out_valid, tx_out_ready;

    int vectors     = 0;
    int miscompares = 0;

    logic [33:0] rd_exp_q[$];
    logic [1:0]  wr_exp_q[$];
    logic [7:0]  tx_exp_q[$];
    logic [7:0]  rx_model_q[$];

    uart_axi_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rstn(rstn),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .rx_in_data(rx_in_data), .rx_in_valid(rx_in_valid), .rx_in_ready(rx_in_ready),
        .tx_out_data(tx_out_data), .tx_out_valid(tx_out_valid), .tx_out_ready(tx_out_ready)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference model
    function automatic logic [33:0] model_read(input logic [31:0] addr);
        logic [3:0] ofs;
        ofs = addr[3:0];
        if (ofs == 4'h0) begin
            if (rx_model_q.size() > 0) return {OKAY, 24'h0, rx_model_q.pop_front()};
            return {SLVERR, 32'h0};
        end
`ifdef UART_AXI_STATUS_EN
        if (ofs == 4'h8)
            return {OKAY, 28'h0, tx_exp_q.size() == DEPTH, tx_exp_q.size() == 0,
                    rx_model_q.size() == DEPTH, rx_model_q.size() != 0};
`endif
        return {SLVERR, 32'h0};
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb);
        if (addr[3:0] != 4'h4) return SLVERR;
        if (!strb[0]) return OKAY;
        if (tx_exp_q.size() >= DEPTH) return SLVERR;
        tx_exp_q.push_back(data[7:0]);
        return OKAY;
    endfunction

    // driver tasks
    task automatic wait_rdy(input int sel, input string name, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 50; n++) begin
            case (sel)
                0:       ok = s_arready;
                1:       ok = s_awready;
                2:       ok = s_wready;
                default: ok = s_awready && s_wready;
            endcase
            if (ok) break;
            @(negedge clk);
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: ready never rose within 50 cycles", name);
        end
    endtask

    task automatic rd(input logic [31:0] addr, input int rdelay);
        bit ok;
        s_araddr  = addr;
        s_arvalid = 1'b1;
        wait_rdy(0, "ar", ok);
        if (ok) rd_exp_q.push_back(model_read(addr));
        tick();
        s_arvalid = 1'b0;
        if (!ok) return;
        chk("rvalid_latency", s_rvalid, 1);
        repeat (rdelay) tick();
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
        chk("rvalid_clear", s_rvalid, 0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input int lead, input int bdelay);
        bit ok;
        s_awaddr = addr;
        s_wdata  = data;
        s_wstrb  = strb;
        if (lead == 0) begin
            s_awvalid = 1'b1;
            s_wvalid  = 1'b1;
            wait_rdy(3, "aw_w", ok);
        end else begin
            s_awvalid = 1'b1;
            wait_rdy(1, "aw", ok);
            tick();
            s_awvalid = 1'b0;
            chk("awready_low", s_awready, 0);
            chk("bvalid_early", s_bvalid, 0);
            repeat (lead - 1) tick();
            s_wvalid = 1'b1;
            wait_rdy(2, "w", ok);
        end
        if (ok) wr_exp_q.push_back(model_write(addr, data, strb));
        tick();
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        if (!ok) return;
        chk("bvalid_latency", s_bvalid, 1);
        repeat (bdelay) begin
            tick();
            chk("bvalid_hold", s_bvalid, 1);
        end
        chk("ready_low", {s_awready, s_wready}, 0);
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        chk("ready_back", {s_awready, s_wready, s_bvalid}, 3'b110);
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_in_data  = b;
        rx_in_valid = 1'b1;
        @(negedge clk);
        chk("rx_in_ready", rx_in_ready, rx_model_q.size() < DEPTH);
        if (rx_model_q.size() < DEPTH) rx_model_q.push_back(b);
        tick();
        rx_in_valid = 1'b0;
    endtask

    task automatic tx_drain(input int n);
        if (tx_exp_q.size() > 0) chk("tx_head", tx_out_data, tx_exp_q[0]);
        chk("tx_valid_pre", tx_out_valid, tx_exp_q.size() != 0);
        tx_out_ready = 1'b1;
        repeat (n) tick();
        tx_out_ready = 1'b0;
        chk("tx_valid_post", tx_out_valid, tx_exp_q.size() != 0);
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        a = $urandom;
        case ($urandom_range(0, 4))
            0:       a[3:0] = 4'h0;
            1:       a[3:0] = 4'h4;
            2:       a[3:0] = 4'h8;
            3:       a[3:0] = 4'hC;
            default: a[3:0] = 4'($urandom_range(0, 15));
        endcase
        return a;
    endfunction

    task automatic chk_reset_values(input string name);
        chk({name, "_ready"}, {s_arready, s_awready, s_wready, rx_in_ready}, 4'b1111);
        chk({name, "_valid"}, {s_rvalid, s_bvalid, tx_out_valid}, 3'b000);
        chk({name, "_rdata"}, s_rdata, 0);
        chk({name, "_resp"}, {s_rresp, s_bresp}, 0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rstn) begin
            if (s_rvalid && s_rready) begin
                if (rd_exp_q.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("rd_resp", {s_rresp, s_rdata}, rd_exp_q.pop_front());
            end
            if (s_bvalid && s_bready) begin
                if (wr_exp_q.size() == 0) chk("wr_unexpected", 1, 0);
                else chk("wr_resp", s_bresp, wr_exp_q.pop_front());
            end
            if (tx_out_valid && tx_out_ready) begin
                if (tx_exp_q.size() == 0) chk("tx_unexpected", 1, 0);
                else chk("tx_byte", tx_out_data, tx_exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        miscompares++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        rstn = 1'b0;
        s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0; rx_in_data = '0; rx_in_valid = 1'b0; tx_out_ready = 1'b0;
        repeat (3) tick();
        chk_reset_values("reset");
        rstn = 1'b1;
        tick();

        // empty RX read, then a real byte
        rd(32'h0, 0);
        rx_push(8'h41);
        rd(32'h0, 1);

        // single TX write and drain
        wr(32'h4, 32'h55, 4'b0001, 0, 0);
        chk("tx_out_valid_after_wr", tx_out_valid, 1);
        chk("tx_out_data_after_wr", tx_out_data, 8'h55);
        tx_drain(1);

        // TX overflow: DEPTH OKAY writes then one SLVERR
        for (int k = 0; k <= DEPTH; k++) wr(32'h4, 32'(k), 4'b0001, 0, 0);
        tx_drain(DEPTH + 2);

        // AW well ahead of W, slow bready; strobe-less and off-map writes
        wr(32'h4, 32'h77, 4'b0001, 3, 2);
        wr(32'h4, 32'h88, 4'b1110, 1, 0);
        wr(32'h8, 32'h1, 4'b1111, 0, 1);
        wr(32'hC, 32'h2, 4'b1111, 2, 0);
        wr(32'h1000_0004, 32'h99, 4'b0001, 0, 0);
        tx_drain(4);

        // push into RX in the same cycle a 1-entry RX is read
        rx_push(8'h11);
        s_araddr = 32'h0; s_arvalid = 1'b1; s_rready = 1'b1;
        rx_in_data = 8'hAA; rx_in_valid = 1'b1;
        @(negedge clk);
        chk("same_cycle_ready", {s_arready, rx_in_ready}, 2'b11);
        rd_exp_q.push_back(model_read(32'h0));
        rx_model_q.push_back(8'hAA);
        tick();
        s_arvalid = 1'b0; rx_in_valid = 1'b0;
        chk("same_cycle_rvalid", s_rvalid, 1);
        tick();
        s_rready = 1'b0;
        rd(32'h8, 1);
        rd(32'h0, 0);
        rd(32'h0, 0);

        // RX fill past full, then read back in order
        for (int k = 0; k <= DEPTH; k++) rx_push(8'(8'hC0 + k));
        rd(32'h8, 0);
        for (int k = 0; k < DEPTH; k++) rd(32'h0, k % 2);

        // reset with responses pending and both FIFOs holding data
        rx_push(8'h01);
        rx_push(8'h02);
        wr(32'h4, 32'h33, 4'b0001, 0, 0);
        s_araddr = 32'h0; s_arvalid = 1'b1;
        s_awaddr = 32'h4; s_wdata = 32'h44; s_wstrb = 4'b0001; s_awvalid = 1'b1; s_wvalid = 1'b1;
        tick();
        s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
        tick();
        chk("pending_before_reset", {s_rvalid, s_bvalid}, 2'b11);
        rstn = 1'b0;
        tick();
        chk_reset_values("midreset");
        rx_model_q.delete();
        tx_exp_q.delete();
        rstn = 1'b1;
        tick();
        rd(32'h0, 0);

        // randomised traffic
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 5))
                0:       rx_push(8'($urandom_range(0, 255)));
                1:       rd(pick_addr(), $urandom_range(0, 3));
                2:       rd(32'h0, $urandom_range(0, 1));
                3:       wr(pick_addr(), $urandom, 4'($urandom_range(0, 15)),
                            $urandom_range(0, 3), $urandom_range(0, 2));
                4:       wr(32'h4, $urandom, 4'b0001, $urandom_range(0, 2), $urandom_range(0, 1));
                default: tx_drain($urandom_range(1, 4));
            endcase
        end
        tx_drain(DEPTH + 2);
        repeat (3) tick();
        chk("rd_exp_q_empty", rd_exp_q.size(), 0);
        chk("wr_exp_q_empty", wr_exp_q.size(), 0);
        chk("tx_exp_q_empty", tx_exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_axi_responder.md
Name: uart_axi_responder

Overview:
AXI4-Lite responder that implements the UART register map used by the core's UART master side.
- 0x0: RX byte FIFO (read-pop).
- 0x4: TX byte FIFO (write-push).
- 0x8: optional status register.
- Byte-stream ports connect to a serialiser/deserialiser or a testbench host model.
- Empty-RX reads and full-TX writes return SLVERR so the master retries; no data is lost and the AXI bus never stalls.

Parameters:
DEPTH, 16, entries per FIFO (power of two, 2..256)
AW, 4, width of the decoded address bits

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
s_araddr  in  32  read address; bits [AW-1:0] decoded
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rdata  out  32  read data
s_rresp  out  2  read response
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
s_awaddr  in  32  write address
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_wdata  in  32  write data
s_wstrb  in  4  write strobes
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_bresp  out  2  write response
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
rx_in_data  in  8  byte from line side
rx_in_valid  in  1  byte valid
rx_in_ready  out  1  RX FIFO not full
tx_out_data  out  8  byte to line side (FIFO head)
tx_out_valid  out  1  TX FIFO not empty
tx_out_ready  in  1  line side consumes byte

Behaviour:
- Interface: reset rstn, synchronous, active-low; clock clk. All state updates on posedge clk.
- Reset values:
  - s_arready=1, s_awready=1, s_wready=1, s_rvalid=0, s_bvalid=0.
  - s_rdata=0, s_rresp=0, s_bresp=0.
  - Both FIFOs empty: rx_in_ready=1, tx_out_valid=0.
- Reset mid-transaction aborts it: pending responses are dropped and FIFO contents are discarded.
- Read channel:
  - s_arready = ~s_rvalid.
  - On s_arvalid&&s_arready, s_rvalid=1 in the next cycle (1-cycle latency).
  - Offset 0x0, RX non-empty: rdata={24'h0,head}, rresp=OKAY, pop in the same cycle the address is accepted.
  - Offset 0x0, RX empty: rdata=0, rresp=SLVERR(2'b10), no pop.
  - Offset 0x4: rdata=0, rresp=SLVERR.
  - Offset 0x8: see Optional Feature; when the feature is absent, SLVERR.
  - Other offsets: SLVERR.
  - rvalid/rdata/rresp are held stable until s_rready; they clear in the cycle after the handshake.
- Write channel:
  - AW and W are accepted independently.
  - Each accepted beat is latched, and its ready drops until the response handshake completes.
  - When both are latched, s_bvalid=1 in the next cycle.
  - AW and W arriving in the same cycle gives s_bvalid 1 cycle later.
  - Offset 0x4, wstrb[0]=1, TX not full: push wdata[7:0], bresp=OKAY.
  - Offset 0x4, TX full: no push, bresp=SLVERR.
  - Offset 0x4, wstrb[0]=0: no push, OKAY.
  - Any other offset: no side effect, bresp=SLVERR.
  - s_bvalid is held until s_bready; awready/wready reassert in the cycle after the handshake.
- FIFOs:
  - Circular buffers with log2(DEPTH)-bit pointers that wrap modulo DEPTH.
  - Occupancy count is log2(DEPTH)+1 bits.
  - Push and pop in the same cycle leave the count unchanged (legal even when full, because pop uses the registered count).
  - A push when full is ignored: rx_in_ready=0 protects the RX side; SLVERR protects the TX side.
  - A pop when empty is ignored.
  - TX pops on tx_out_valid&&tx_out_ready.
  - RX pushes on rx_in_valid&&rx_in_ready.
- Byte ordering: FIFO order, first in first out.

Optional Feature:
Macro UART_AXI_STATUS_EN.
- Defined: offset 0x8 reads OKAY with rdata = {28'h0, tx_full, tx_empty, rx_full, rx_valid} (bit0 = RX non-empty). Writes to 0x8 return SLVERR.
- Undefined: 0x8 reads return SLVERR, rdata=0.

Decomposition:
- Package uart_axi_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - OFS_RX=4'h0, OFS_TX=4'h4, OFS_STAT=4'h8.
  - Status bit indices.
- Sub-module byte_fifo (params DEPTH):
  - Ports: push, push_data, pop, head, full, empty, count.
  - Instantiated twice, once for RX and once for TX.

Test Plan:
- Read 0x0 with RX empty -> rvalid 1 cycle after AR, rresp=2'b10, rdata=0. Then push 0x41 on rx_in and re-read -> rresp=00, rdata=32'h00000041.
- Write 0x4 with wdata=0x55, wstrb=4'b0001 -> bresp=00 and tx_out_valid=1 with tx_out_data=0x55. Pulse tx_out_ready -> tx_out_valid=0.
- Hold tx_out_ready=0 and write DEPTH+1 bytes -> first 16 writes return OKAY, 17th returns SLVERR. Drain -> bytes 0..15 appear in order.
- AW issued 3 cycles before W, with bready held low for 2 cycles -> single bvalid, 1 cycle after W accepted, held stable. awready/wready stay low until the handshake.
- With s_rready=1, push 0xAA to RX in the same cycle as accepting a read of a 1-entry RX FIFO -> read returns the old head and 0xAA remains. With UART_AXI_STATUS_EN, a read of 0x8 -> rdata[0]=1.
- Assert rstn=0 with rvalid and bvalid pending and FIFOs holding data -> the next cycle shows all outputs at reset values and rx_in_ready=1.
